data_bus_responder: RTL and testbench

- Target-side responder for the core's data bus.
- Serves load/store requests issued through the bus control path: word-organised data RAM, byte/half/word access, fixed wait states, ready/busy handshake, fault reporting.
- Sits in the top level beside the core and answers requests decoded into its address window.
- Load data is returned right-aligned and zero-extended; sign extension stays in the core.

---
 rtl/data_bus_responder.sv | 223 ++++++++++++++++++++++
 tb/tb_data_bus_responder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_bus_responder.sv
// data_bus_responder: target-side data-bus responder with a word-organised RAM.
// Byte/half/word loads and stores, fixed wait states, RAM cleared after reset,
// fault reporting for malformed or out-of-window requests.
// Optional per-byte even parity is enabled with `define DATA_BUS_RESPONDER_PARITY_EN.
module data_bus_responder #(
    parameter int          DATA_ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_1000,
    parameter int          WAIT_CYCLES     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wd,
    input  logic        rd,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic        fault
`ifdef DATA_BUS_RESPONDER_PARITY_EN
    ,
    input  logic        parity_flip
`endif
);

    localparam int          DEPTH    = 2 ** DATA_ADDR_WIDTH;
    localparam logic [31:0] DEPTH_W  = 32'(DEPTH);
    localparam int          CW       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t state_reg, state_next;

    logic [DATA_ADDR_WIDTH-1:0] init_idx_reg;
    logic [DATA_ADDR_WIDTH-1:0] idx_reg;
    logic [1:0]                 lane_reg;
    logic [1:0]                 size_reg;
    logic [31:0]                wdata_reg;
    logic                       op_write_reg;
    logic                       fault_reg;
    logic [CW-1:0]              cnt_reg;

    logic        req;
    logic [31:0] offset;
    logic        req_fault;
    logic        last_access;
    logic        mem_we;
    logic [DATA_ADDR_WIDTH-1:0] mem_addr;
    logic [3:0]  be_req;
    logic [3:0]  be;
    logic [31:0] wr_word;
    logic [31:0] rd_word;
    logic [31:0] rd_ext;
    logic        par_err;
    logic        resp_fault;

    assign req         = wd | rd;
    assign offset      = addr - BASE_ADDR;
    assign last_access = (state_reg == S_ACCESS) && (cnt_reg == LAST_CNT);

    // Request screening, evaluated on the live bus while idle
    always_comb begin
        req_fault = 1'b0;
        if (wd && rd)                                req_fault = 1'b1;
        else if (size == 2'b11)                      req_fault = 1'b1;
        else if (size == 2'b01 && addr[0])           req_fault = 1'b1;
        else if (size == 2'b10 && addr[1:0] != 2'b0) req_fault = 1'b1;
        else if (addr < BASE_ADDR)                   req_fault = 1'b1;
        else if ((offset >> 2) >= DEPTH_W)           req_fault = 1'b1;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_reg <= S_INIT;
        else     state_reg <= state_next;
    end

    // Request latch, wait counter and init sweep index
    always_ff @(posedge clk) begin
        if (rst) begin
            init_idx_reg <= '0;
            idx_reg      <= '0;
            lane_reg     <= '0;
            size_reg     <= '0;
            wdata_reg    <= '0;
            op_write_reg <= 1'b0;
            fault_reg    <= 1'b0;
            cnt_reg      <= '0;
        end else begin
            if (state_reg == S_INIT) init_idx_reg <= init_idx_reg + 1'b1;
            if (state_reg == S_IDLE && req) begin
                idx_reg      <= offset[DATA_ADDR_WIDTH+1:2];
                lane_reg     <= addr[1:0];
                size_reg     <= size;
                wdata_reg    <= wdata;
                op_write_reg <= wd;
                fault_reg    <= req_fault;
                cnt_reg      <= '0;
            end else if (state_reg == S_ACCESS) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    // Next-state logic and handshake outputs
    always_comb begin
        state_next = state_reg;
        ready      = 1'b1;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            S_INIT: begin
                ready = 1'b0;
                if (init_idx_reg == {DATA_ADDR_WIDTH{1'b1}}) state_next = S_IDLE;
            end
            S_IDLE: begin
                if (req) state_next = req_fault ? S_RESP : S_ACCESS;
            end
            S_ACCESS: begin
                busy = 1'b1;
                if (cnt_reg == LAST_CNT) state_next = S_RESP;
            end
            S_RESP: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_INIT;
        endcase
    end

    // Lane enables and lane-replicated store data
    always_comb begin
        case (size_reg)
            2'b00:   be_req = 4'b0001 << lane_reg;
            2'b01:   be_req = lane_reg[1] ? 4'b1100 : 4'b0011;
            default: be_req = 4'b1111;
        endcase
        if (state_reg == S_INIT) begin
            be      = 4'b1111;
            wr_word = 32'h0;
        end else begin
            be = be_req;
            case (size_reg)
                2'b00:   wr_word = {4{wdata_reg[7:0]}};
                2'b01:   wr_word = {2{wdata_reg[15:0]}};
                default: wr_word = wdata_reg;
            endcase
        end
    end

    assign mem_we   = (state_reg == S_INIT) || (last_access && op_write_reg);
    assign mem_addr = (state_reg == S_INIT) ? init_idx_reg : idx_reg;

`ifdef DATA_BUS_RESPONDER_PARITY_EN
    logic [3:0] wr_par;
    logic [3:0] rd_par;
`endif

    // One RAM per byte lane so each lane's write enable stays independent
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] ram [DEPTH];
            logic [7:0] rd_byte_reg;

            // Lane write on enable; registered read while accessing
            always_ff @(posedge clk) begin
                if (!rst && mem_we && be[gi]) ram[mem_addr] <= wr_word[gi*8 +: 8];
                if (state_reg == S_ACCESS) rd_byte_reg <= ram[mem_addr];
            end
            assign rd_word[gi*8 +: 8] = rd_byte_reg;

`ifdef DATA_BUS_RESPONDER_PARITY_EN
            logic par_ram [DEPTH];
            logic par_rd_reg;

            assign wr_par[gi] = (state_reg == S_INIT) ? 1'b0 :
                                ((^wr_word[gi*8 +: 8]) ^ ((gi == 0) && parity_flip));

            // Parity bit write and registered read alongside the data lane
            always_ff @(posedge clk) begin
                if (!rst && mem_we && be[gi]) par_ram[mem_addr] <= wr_par[gi];
                if (state_reg == S_ACCESS) par_rd_reg <= par_ram[mem_addr];
            end
            assign rd_par[gi] = par_rd_reg;
`endif
        end
    endgenerate

    // Lane extraction with zero extension
    always_comb begin
        logic [31:0] shifted;
        shifted = rd_word >> {lane_reg, 3'b000};
        case (size_reg)
            2'b00:   rd_ext = {24'h0, shifted[7:0]};
            2'b01:   rd_ext = {16'h0, shifted[15:0]};
            default: rd_ext = rd_word;
        endcase
    end

`ifdef DATA_BUS_RESPONDER_PARITY_EN
    // Any accessed byte whose recomputed parity disagrees with storage faults a load
    always_comb begin
        logic [3:0] calc;
        for (int i = 0; i < 4; i++) calc[i] = ^rd_word[i*8 +: 8];
        par_err = !op_write_reg && (|(be_req & (calc ^ rd_par)));
    end
`else
    assign par_err = 1'b0;
`endif

    // Response outputs, meaningful only during the single RESP cycle
    always_comb begin
        resp_fault = fault_reg | par_err;
        fault      = (state_reg == S_RESP) && resp_fault;
        rdata      = 32'h0;
        if (state_reg == S_RESP && !resp_fault && !op_write_reg) rdata = rd_ext;
    end

endmodule

// File: tb/tb_data_bus_responder.sv
// Testbench for data_bus_responder: directed and randomized requests checked
// against a byte-addressed memory model built from the access rules.
module tb_data_bus_responder;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          AW    = 10;
    localparam int          WAIT  = 1;
    localparam int          BYTES = 4 * (2 ** AW);

    logic        clk = 1'b0;
    logic        rst;
    logic        wd;
    logic        rd;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        busy;
    logic        done;
    logic        fault;
    logic        parity_flip = 1'b0;

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0] mem_b   [BYTES];
    bit         par_bad [BYTES];

    data_bus_responder #(
        .DATA_ADDR_WIDTH(AW),
        .BASE_ADDR(BASE),
        .WAIT_CYCLES(WAIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wd(wd),
        .rd(rd),
        .size(size),
        .addr(addr),
        .wdata(wdata),
        .rdata(rdata),
        .ready(ready),
        .busy(busy),
        .done(done),
        .fault(fault)
`ifdef DATA_BUS_RESPONDER_PARITY_EN
        ,
        .parity_flip(parity_flip)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit model_fault(input logic w, input logic r, input logic [1:0] sz,
                                       input logic [31:0] a);
        logic [31:0] off;
        if (w && r) return 1'b1;
        if (sz == 2'd3) return 1'b1;
        if (sz == 2'd1 && a[0]) return 1'b1;
        if (sz == 2'd2 && a[1:0] != 2'd0) return 1'b1;
        if (a < BASE) return 1'b1;
        off = a - BASE;
        if (off >= 32'(BYTES)) return 1'b1;
        if (r) begin
            for (int i = 0; i < (1 << sz); i++)
                if (par_bad[off + 32'(i)]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic do_reset();
        int  cyc;
        bit  noisy;
        rst = 1'b1; wd = 1'b0; rd = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_done",  32'(done),  32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        for (int i = 0; i < BYTES; i++) begin
            mem_b[i] = 8'h0;
            par_bad[i] = 1'b0;
        end
        rst = 1'b0;
        wd = 1'b1; size = 2'd2; addr = BASE; wdata = 32'hFFFF_FFFF;
        cyc = 0; noisy = 1'b0;
        while (!ready && cyc < 3 * BYTES) begin
            @(negedge clk);
            cyc++;
            if (cyc == 5) wd = 1'b0;
            if (busy || done) noisy = 1'b1;
        end
        wd = 1'b0;
        chk("init_cycles", 32'(cyc), 32'(BYTES / 4));
        chk("init_quiet", 32'(noisy), 32'd0);
        $display("reset: ready after %0d cycles", cyc);
    endtask

    task automatic do_req(input logic w, input logic r, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] d, input bit hold);
        bit          ef;
        logic [31:0] er;
        logic [31:0] off;
        int          lat;
        bit          seen;
        ef  = model_fault(w, r, sz, a);
        off = a - BASE;
        er  = 32'h0;
        if (!ef && r)
            for (int i = 0; i < (1 << sz); i++)
                er = er | (32'(mem_b[off + 32'(i)]) << (8 * i));
        @(negedge clk);
        wd = w; rd = r; size = sz; addr = a; wdata = d;
        @(posedge clk);
        #1;
        if (!hold) begin wd = 1'b0; rd = 1'b0; end
        lat = 0; seen = 1'b0;
        while (!seen && lat < 8) begin
            @(negedge clk);
            lat++;
            if (done) seen = 1'b1;
        end
        chk($sformatf("done_seen@%h", a), 32'(seen), 32'd1);
        if (seen) begin
            chk($sformatf("latency@%h", a), 32'(lat), ef ? 32'd1 : 32'(WAIT + 1));
            chk($sformatf("fault@%h", a), 32'(fault), 32'(ef));
            if (r || ef) chk($sformatf("rdata@%h", a), rdata, er);
        end
        wd = 1'b0; rd = 1'b0;
        if (!ef && w)
            for (int i = 0; i < (1 << sz); i++) begin
                mem_b[off + 32'(i)]   = d[8*i +: 8];
                par_bad[off + 32'(i)] = parity_flip && (((off + 32'(i)) % 4) == 0);
            end
        $display("req wd=%0d rd=%0d size=%0d addr=%h wdata=%h -> lat=%0d fault=%0d rdata=%h (exp fault=%0d rdata=%h)",
                 w, r, sz, a, d, lat, fault, rdata, ef, er);
        @(negedge clk);
        chk("post_done", 32'(done), 32'd0);
        chk("post_rdata", rdata, 32'd0);
    endtask

    initial begin
        rst = 1'b1; wd = 1'b0; rd = 1'b0; size = 2'd0; addr = 32'h0; wdata = 32'h0;
        do_reset();

        // Directed word/byte/half accesses and faults
        do_req(1, 0, 2'd2, 32'h1004, 32'hDEAD_BEEF, 1);
        do_req(0, 1, 2'd2, 32'h1004, 32'h0, 1);
        do_req(1, 0, 2'd0, 32'h1006, 32'h0000_005A, 1);
        do_req(0, 1, 2'd2, 32'h1004, 32'h0, 0);
        do_req(0, 1, 2'd0, 32'h1007, 32'h0, 1);
        do_req(0, 1, 2'd1, 32'h1006, 32'h0, 0);
        do_req(0, 1, 2'd1, 32'h1005, 32'h0, 1);
        do_req(1, 0, 2'd2, 32'h2000, 32'hCAFE_F00D, 1);
        do_req(0, 1, 2'd2, 32'h1000, 32'h0, 1);
        do_req(0, 1, 2'd2, 32'h1004, 32'h0, 1);
        do_req(1, 1, 2'd2, 32'h1008, 32'h1234_5678, 1);
        do_req(0, 1, 2'd2, 32'h0FFC, 32'h0, 0);
        do_req(0, 1, 2'd3, 32'h1000, 32'h0, 0);
        do_req(1, 0, 2'd2, 32'h1FFC, 32'hA5A5_0F0F, 1);
        do_req(0, 1, 2'd2, 32'h1FFC, 32'h0, 1);

`ifdef DATA_BUS_RESPONDER_PARITY_EN
        parity_flip = 1'b1;
        do_req(1, 0, 2'd2, 32'h1000, 32'h1122_3344, 1);
        parity_flip = 1'b0;
        do_req(0, 1, 2'd2, 32'h1000, 32'h0, 1);
        do_req(0, 1, 2'd0, 32'h1001, 32'h0, 1);
`endif

        // Randomized traffic concentrated in a small window so loads hit stores
        for (int n = 0; n < 300; n++) begin
            int          k;
            int          s;
            logic        w;
            logic        r;
            logic [1:0]  sz;
            logic [31:0] a;
            k = $urandom_range(0, 99);
            w = (k < 45) || (k >= 94);
            r = (k >= 45);
            s = $urandom_range(0, 19);
            sz = (s < 6) ? 2'd0 : (s < 12) ? 2'd1 : (s < 19) ? 2'd2 : 2'd3;
            if ($urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 1) == 0) a = BASE - 32'(4 * $urandom_range(1, 8));
                else                           a = BASE + 32'(BYTES) + 32'($urandom_range(0, 63));
            end else begin
                a = 32'($urandom_range(0, 63));
                if ($urandom_range(0, 9) < 8) begin
                    if (sz == 2'd2) a = a & ~32'd3;
                    else if (sz == 2'd1) a = a & ~32'd1;
                end
                a = BASE + a;
            end
            do_req(w, r, sz, a, $urandom, bit'($urandom_range(0, 1)));
        end

        // Reset during ACCESS must abort the store with no completion
        @(negedge clk);
        wd = 1'b1; rd = 1'b0; size = 2'd2; addr = 32'h1010; wdata = 32'h1122_3344;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd1);
        chk("abort_done", 32'(done), 32'd0);
        do_reset();
        do_req(0, 1, 2'd2, 32'h1010, 32'h0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
